draw_board_region: RTL and testbench
====================================

# draw_board_region

Parametrised successor to the fixed 10-column board painter. Rasterises a selectable band of board rows from the synchronous board RAM into CELL×CELL pixel squares for the VGA adapter, with a start/busy/done handshake. It supports three modes: full redraw, draw non-empty cells only, and fill with a background colour. It sits between the game FSM, the board RAM read port, and the VGA plot interface.

## Interface
- COLS, 10, board columns
- ROWS, 24, board rows including hidden rows
- HIDDEN_ROWS, 4, top rows never drawn
- CELL_LOG2, 2, cell edge = 2^CELL_LOG2 pixels
- X_ORIGIN, 60, screen X of column 0 pixel 0
- Y_ORIGIN, 12, screen Y of first visible row
- COLOUR_W, 6, colour width
- FILL_COLOUR, 0, colour used in fill mode
- ADDR_W, $clog2(ROWS*COLS), RAM address width
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- mode  in  2  00 draw all, 01 skip empty (ram_q==0), 10 fill, 11 treated as 00
- row_first  in  $clog2(ROWS)  first absolute row to draw
- row_last  in  $clog2(ROWS)  last absolute row to draw
- ram_addr  out  ADDR_W  row*COLS+col; combinational from counters
- ram_q  in  COLOUR_W  RAM data; valid one cycle after address sampled
- X  out  8  pixel X
- Y  out  7  pixel Y
- colour  out  COLOUR_W  pixel colour
- plot  out  1  VGA write enable
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FETCH0, FETCH1, DRAW, DONE.
- IDLE: if start, latch mode and row bounds, set col=0, row=max(row_first, HIDDEN_ROWS) → FETCH0. Clamp the latched row_last to ROWS-1. If the clamped first > clamped last → DONE with no plots.
- FETCH0: address stable; RAM samples at end of cycle. FETCH1: capture ram_q into cell colour register (fill mode: capture FILL_COLOUR) → DRAW.
- Skip-empty mode with captured ram_q==0: FETCH1 goes directly to next cell (FETCH0) or DONE; no plots are issued.
- DRAW: lasts 2^(2·CELL_LOG2) cycles; pixel counter i; ox=i[CELL_LOG2-1:0] (fastest), oy=i upper bits.
  - X = X_ORIGIN + (col<<CELL_LOG2) + ox
  - Y = Y_ORIGIN + ((row-HIDDEN_ROWS)<<CELL_LOG2) + oy
  - Arithmetic is truncated to 8/7 bits. Parameters must satisfy X_ORIGIN+COLS·2^CELL_LOG2 ≤ 256 and Y_ORIGIN+(ROWS-HIDDEN_ROWS)·2^CELL_LOG2 ≤ 128; check this with an elaboration-time assertion.
- Last pixel of a cell: col==COLS-1 wraps col to 0 and increments row; a cell at (row_last, COLS-1) goes to DONE; otherwise → FETCH0.
- DONE: done=1 for one cycle → IDLE.
- plot=1 only in DRAW; X/Y/colour hold their last values elsewhere.
- start while busy or in DONE is ignored (not queued).

## Timing
- Reset values: state IDLE, plot 0, busy 0, done 0, X 0, Y 0, colour 0, counters 0.
- Reset mid-operation: next cycle IDLE, plot 0, no done pulse.
- Cycle 0 = start sampled. Cycle 1 FETCH0, cycle 2 FETCH1, cycles 3..2+2^(2·CELL_LOG2) plot.
- Cell cost: 2+CELL² cycles when drawn; 2 cycles when skipped. No bubbles between cells beyond the two fetch cycles.
- Full visible board (rows 4–23, 10 columns, CELL=4, mode 00): 200 cells × 18 = 3600 busy cycles; done in cycle 3601; start is accepted again from cycle 3602.

## Structure
- Shared package tetris_draw_pkg:
  - mode encodings: MODE_ALL, MODE_SKIP, MODE_FILL
  - state enum
  - screen width constants: 8/7
- Sub-module cell_addr (row, col → row*COLS+col, combinational, parametrised COLS/ADDR_W), replacing the fixed coord_to_addr.

## Test plan
- Mode 00, rows 4–23, RAM addr holds addr[5:0]:
  - exactly 3200 plots, done in cycle 3601
  - first plot (60,12) colour 40
  - last plot (99,91) colour 239[5:0]
- Mode 01, rows 4–23, only cell (7,12) non-zero = 6'h15:
  - 16 plots at X 88–91, Y 44–47, colour 6'h15
  - done after 199·2+18 cycles
- Mode 10, row_first=row_last=22, FILL_COLOUR=0:
  - 160 plots, all colour 0, Y 84–87
  - ram_q ignored (drive X/garbage)
- row_first=2, row_last=30: clamped to 4–23, same result as the full board. row_first=10, row_last=5: done in cycle 1, zero plots.
- start re-asserted during busy → ignored. reset asserted in cycle 50 → IDLE next cycle, plot 0, no done; new start then completes normally.
- CELL_LOG2=3, COLS=8, ROWS=12, HIDDEN_ROWS=0:
  - 64 plots per cell, ox fastest
  - done in cycle 1+96·66

Source files
------------

// File: rtl/tetris_draw_pkg.sv
// Shared types and constants for the board-region painter: plot modes,
// painter FSM states and VGA coordinate widths.
package tetris_draw_pkg;

  localparam int SCREEN_X_W = 8;
  localparam int SCREEN_Y_W = 7;

  typedef enum logic [1:0] {
    MODE_ALL  = 2'b00,
    MODE_SKIP = 2'b01,
    MODE_FILL = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    FETCH1,
    DRAW,
    DONE
  } state_e;

  // The reserved encoding 2'b11 behaves as a full redraw.
  function automatic mode_e decode_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_ALL : mode_e'(m);
  endfunction

endpackage

// File: rtl/draw_board_region_if.sv
// Request, board-RAM read and VGA plot signals of the region painter.
// The slave modport is the painter; the master side is game FSM + RAM + VGA.
interface draw_board_region_if
  import tetris_draw_pkg::*;
#(
  parameter int ROWS     = 24,
  parameter int COLS     = 10,
  parameter int COLOUR_W = 6,
  parameter int ADDR_W   = $clog2(ROWS * COLS),
  parameter int ROW_W    = $clog2(ROWS)
) ();

  logic                  start;
  logic [1:0]            mode;
  logic [ROW_W-1:0]      row_first;
  logic [ROW_W-1:0]      row_last;
  logic [ADDR_W-1:0]     ram_addr;
  logic [COLOUR_W-1:0]   ram_q;
  logic [SCREEN_X_W-1:0] X;
  logic [SCREEN_Y_W-1:0] Y;
  logic [COLOUR_W-1:0]   colour;
  logic                  plot;
  logic                  busy;
  logic                  done;

  modport master (
    output start, mode, row_first, row_last, ram_q,
    input  ram_addr, X, Y, colour, plot, busy, done
  );

  modport slave (
    input  start, mode, row_first, row_last, ram_q,
    output ram_addr, X, Y, colour, plot, busy, done
  );

endinterface

// File: rtl/cell_addr.sv
// Board RAM address of a cell: row * COLS + col, purely combinational.
module cell_addr #(
  parameter int COLS   = 10,
  parameter int ROW_W  = 5,
  parameter int COL_W  = 4,
  parameter int ADDR_W = 8
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr
);

  assign addr = ADDR_W'(int'(row) * COLS + int'(col));

endmodule

// File: rtl/draw_board_region.sv
// Rasterises a band of board rows from the board RAM into CELL x CELL
// squares on the VGA plot port, with a start/busy/done handshake.
module draw_board_region
  import tetris_draw_pkg::*;
#(
  parameter int COLS        = 10,
  parameter int ROWS        = 24,
  parameter int HIDDEN_ROWS = 4,
  parameter int CELL_LOG2   = 2,
  parameter int X_ORIGIN    = 60,
  parameter int Y_ORIGIN    = 12,
  parameter int COLOUR_W    = 6,
  parameter int FILL_COLOUR = 0,
  parameter int ADDR_W      = $clog2(ROWS * COLS)
) (
  input  logic               clk,
  input  logic               reset,
  draw_board_region_if.slave bus
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PIX_W = 2 * CELL_LOG2;

  localparam logic [ROW_W-1:0] FIRST_VISIBLE = ROW_W'(HIDDEN_ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL      = COL_W'(COLS - 1);
  localparam logic [PIX_W-1:0] LAST_PIX      = '1;

  if (X_ORIGIN + COLS * (2 ** CELL_LOG2) > 256) begin : g_x_range
    $error("draw_board_region: board does not fit the 8-bit X range");
  end
  if (Y_ORIGIN + (ROWS - HIDDEN_ROWS) * (2 ** CELL_LOG2) > 128) begin : g_y_range
    $error("draw_board_region: board does not fit the 7-bit Y range");
  end

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [ROW_W-1:0]      row_q, row_d, row_last_q, row_last_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic [COLOUR_W-1:0]   cell_q, cell_d;
  logic [SCREEN_X_W-1:0] x_q, x_pix;
  logic [SCREEN_Y_W-1:0] y_q, y_pix;
  logic [COLOUR_W-1:0]   colour_q;

  logic [ROW_W-1:0]      row_first_c, row_last_c;
  logic                  last_cell, drawing;
  logic [CELL_LOG2-1:0]  ox, oy;

  cell_addr #(
    .COLS   (COLS),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .ADDR_W (ADDR_W)
  ) u_cell_addr (
    .row  (row_q),
    .col  (col_q),
    .addr (bus.ram_addr)
  );

  assign row_first_c = (bus.row_first < FIRST_VISIBLE) ? FIRST_VISIBLE : bus.row_first;
  assign row_last_c  = (bus.row_last > LAST_ROW) ? LAST_ROW : bus.row_last;
  assign last_cell   = (row_q == row_last_q) && (col_q == LAST_COL);

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no path can infer a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    row_d      = row_q;
    row_last_d = row_last_q;
    col_d      = col_q;
    pix_d      = pix_q;
    cell_d     = cell_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d     = decode_mode(bus.mode);
          row_d      = row_first_c;
          row_last_d = row_last_c;
          col_d      = '0;
          pix_d      = '0;
          state_d    = (row_first_c > row_last_c) ? DONE : FETCH0;
        end
      end
      FETCH0: state_d = FETCH1;
      FETCH1: begin
        if (mode_q == MODE_SKIP && bus.ram_q == '0) begin
          col_d   = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
          row_d   = (col_q == LAST_COL) ? row_q + 1'b1 : row_q;
          state_d = last_cell ? DONE : FETCH0;
        end else begin
          cell_d  = (mode_q == MODE_FILL) ? COLOUR_W'(FILL_COLOUR) : bus.ram_q;
          state_d = DRAW;
        end
      end
      DRAW: begin
        pix_d = pix_q + 1'b1;
        if (pix_q == LAST_PIX) begin
          col_d   = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
          row_d   = (col_q == LAST_COL) ? row_q + 1'b1 : row_q;
          state_d = last_cell ? DONE : FETCH0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel offsets within the cell: ox runs fastest along the row.
  assign ox      = pix_q[CELL_LOG2-1:0];
  assign oy      = pix_q[PIX_W-1:CELL_LOG2];
  assign x_pix   = SCREEN_X_W'(X_ORIGIN + (int'(col_q) << CELL_LOG2) + int'(ox));
  assign y_pix   = SCREEN_Y_W'(Y_ORIGIN + ((int'(row_q) - HIDDEN_ROWS) << CELL_LOG2) + int'(oy));
  assign drawing = (state_q == DRAW);

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments; reset is synchronous and clears every register.
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_ALL;
      row_q      <= '0;
      row_last_q <= '0;
      col_q      <= '0;
      pix_q      <= '0;
      cell_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      row_q      <= row_d;
      row_last_q <= row_last_d;
      col_q      <= col_d;
      pix_q      <= pix_d;
      cell_q     <= cell_d;
      if (drawing) begin
        x_q      <= x_pix;
        y_q      <= y_pix;
        colour_q <= cell_q;
      end
    end
  end

  assign bus.plot   = drawing;
  assign bus.X      = drawing ? x_pix : x_q;
  assign bus.Y      = drawing ? y_pix : y_q;
  assign bus.colour = drawing ? cell_q : colour_q;
  assign bus.busy   = (state_q == FETCH0) || (state_q == FETCH1) || (state_q == DRAW);
  assign bus.done   = (state_q == DONE);

endmodule

// File: tb/tb_draw_board_region.sv
// Randomised bench for draw_board_region: a behavioural model lists every
// expected plot and the completion cycle, and the observed stream is compared.
module tb_draw_board_region;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  localparam int BUDGET = 8000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  draw_board_region_if #(.ROWS(24), .COLS(10), .COLOUR_W(6)) bus_a ();
  draw_board_region_if #(.ROWS(12), .COLS(8), .COLOUR_W(6)) bus_b ();

  draw_board_region u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  draw_board_region #(
    .COLS        (8),
    .ROWS        (12),
    .HIDDEN_ROWS (0),
    .CELL_LOG2   (3)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int   mem [256];
  bit   garbage = 1'b0;
  int   sel = 0;
  int   errors = 0;
  int   checks = 0;
  pix_t exp_q[$];
  pix_t obs_q[$];
  int   exp_done;
  int   last_done;

  // Synchronous board RAM models, one per painter.
  always @(posedge clk) begin
    bus_a.ram_q <= garbage ? 6'($urandom) : 6'(mem[bus_a.ram_addr]);
    bus_b.ram_q <= 6'(mem[bus_b.ram_addr]);
  end

  logic       m_plot, m_busy, m_done;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [5:0] m_colour;

  always_comb begin
    if (sel == 0) begin
      m_plot = bus_a.plot; m_busy = bus_a.busy; m_done = bus_a.done;
      m_x = bus_a.X; m_y = bus_a.Y; m_colour = bus_a.colour;
    end else begin
      m_plot = bus_b.plot; m_busy = bus_b.busy; m_done = bus_b.done;
      m_x = bus_b.X; m_y = bus_b.Y; m_colour = bus_b.colour;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s, input int m, input int rf, input int rl);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    if (sel == 0) begin
      bus_a.start = s; bus_a.mode = 2'(m);
      bus_a.row_first = 5'(rf); bus_a.row_last = 5'(rl);
    end else begin
      bus_b.start = s; bus_b.mode = 2'(m);
      bus_b.row_first = 4'(rf); bus_b.row_last = 4'(rl);
    end
  endtask

  // Expected plot list and done cycle, straight from the painting rules.
  task automatic build_model(input int cols, input int rows, input int hid, input int cl2,
                             input int xo, input int yo, input int mode_i,
                             input int rf, input int rl);
    int m, first, last, e, cycles, v;
    exp_q.delete();
    m      = (mode_i == 3) ? 0 : mode_i;
    first  = (rf < hid) ? hid : rf;
    last   = (rl > rows - 1) ? rows - 1 : rl;
    e      = 1 << cl2;
    cycles = 0;
    for (int r = first; r <= last; r++) begin
      for (int c = 0; c < cols; c++) begin
        v = mem[r * cols + c] & 63;
        if (m == 2) v = 0;
        if (m == 1 && v == 0) begin
          cycles += 2;
        end else begin
          cycles += 2 + e * e;
          for (int oy = 0; oy < e; oy++)
            for (int ox = 0; ox < e; ox++)
              exp_q.push_back('{(xo + c * e + ox) & 255, (yo + (r - hid) * e + oy) & 127, v});
        end
      end
    end
    exp_done = cycles + 1;
  endtask

  task automatic run_test(input string name, input int d, input int m, input int rf,
                          input int rl, input int restart_at, input int reset_at);
    int cyc, busy_cycles, mism, quiet;
    bit finished, rst_taken;
    sel = d;
    obs_q.delete();
    if (d == 0) build_model(10, 24, 4, 2, 60, 12, m, rf, rl);
    else        build_model(8, 12, 0, 3, 60, 12, m, rf, rl);
    @(negedge clk);
    drive(1'b1, m, rf, rl);
    @(negedge clk);
    drive(1'b0, m, rf, rl);
    cyc = 1; busy_cycles = 0; last_done = -1; finished = 0; rst_taken = 0;
    while (!finished && cyc <= BUDGET) begin
      if (m_plot) obs_q.push_back('{int'(m_x), int'(m_y), int'(m_colour)});
      if (m_busy) busy_cycles++;
      if (m_done) begin
        last_done = cyc;
        finished  = 1;
      end else if (cyc == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check({name, "_rst_plot"}, m_plot, 0);
        check({name, "_rst_busy"}, m_busy, 0);
        check({name, "_rst_done"}, m_done, 0);
        check({name, "_rst_xy"}, {m_x, m_y}, 0);
        quiet = 0;
        repeat (20) begin
          @(negedge clk);
          if (m_done || m_busy) quiet++;
        end
        check({name, "_rst_quiet"}, quiet, 0);
        finished  = 1;
        rst_taken = 1;
      end else begin
        if (cyc == restart_at) drive(1'b1, m, 10, 5);
        else                   drive(1'b0, m, rf, rl);
        @(negedge clk);
        cyc++;
      end
    end
    if (!rst_taken) begin
      check({name, "_timeout"}, finished, 1);
      if (!finished) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        // start during DONE must be dropped, not queued
        drive(1'b1, m, rf, rl);
        @(negedge clk);
        drive(1'b0, m, rf, rl);
        quiet = int'(m_busy) + int'(m_done);
        @(negedge clk);
        quiet += int'(m_busy) + int'(m_done);
        check({name, "_idle_after_done"}, quiet, 0);
      end
      mism = 0;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
        if (obs_q[i].x != exp_q[i].x || obs_q[i].y != exp_q[i].y || obs_q[i].c != exp_q[i].c)
          mism++;
      check({name, "_plots"}, obs_q.size(), exp_q.size());
      check({name, "_pixel_mism"}, mism, 0);
      check({name, "_done_cycle"}, last_done, exp_done);
      check({name, "_busy_cycles"}, busy_cycles, exp_done - 1);
    end
  endtask

  initial begin
    sel = 0;
    drive(1'b0, 0, 0, 0);
    sel = 1;
    drive(1'b0, 0, 0, 0);
    sel = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_plot", bus_a.plot, 0);
    check("reset_busy", bus_a.busy, 0);
    check("reset_done", bus_a.done, 0);
    check("reset_xyc", {bus_a.X, bus_a.Y, bus_a.colour}, 0);
    check("reset_addr", bus_a.ram_addr, 0);
    reset = 1'b0;

    // Full visible board, RAM holds its own low address bits.
    for (int i = 0; i < 256; i++) mem[i] = i & 63;
    run_test("full", 0, 0, 4, 23, -1, -1);
    check("full_count", obs_q.size(), 3200);
    check("full_done_at", last_done, 3601);
    if (obs_q.size() > 0) begin
      check("full_first", {obs_q[0].x, obs_q[0].y, obs_q[0].c}, {32'd60, 32'd12, 32'd40});
      check("full_last", {obs_q[$].x, obs_q[$].y, obs_q[$].c}, {32'd99, 32'd91, 32'd47});
    end

    run_test("clamp", 0, 0, 2, 30, -1, -1);
    check("clamp_count", obs_q.size(), 3200);
    run_test("empty", 0, 0, 10, 5, -1, -1);
    check("empty_done_at", last_done, 1);

    // Skip-empty with a single occupied cell at column 7, row 12.
    for (int i = 0; i < 256; i++) mem[i] = 0;
    mem[12 * 10 + 7] = 'h15;
    run_test("skip", 0, 1, 4, 23, -1, -1);
    check("skip_done_at", last_done, 199 * 2 + 18 + 1);
    if (obs_q.size() > 0)
      check("skip_first", {obs_q[0].x, obs_q[0].y, obs_q[0].c}, {32'd88, 32'd44, 32'h15});

    garbage = 1'b1;
    run_test("fill", 0, 2, 22, 22, -1, -1);
    garbage = 1'b0;
    check("fill_count", obs_q.size(), 160);

    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 63));
    run_test("restart", 0, 3, 4, 6, 20, -1);
    run_test("reset_mid", 0, 0, 4, 23, -1, 50);
    run_test("after_reset", 0, 1, 5, 7, -1, -1);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 63));
      run_test($sformatf("rand%0d", t), 0, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), -1, -1);
    end

    // Large cells on a small board: 8x8 squares, ox fastest.
    for (int i = 0; i < 256; i++) mem[i] = int'($urandom_range(0, 63));
    run_test("big_cell", 1, 0, 0, 15, -1, -1);
    check("big_cell_done_at", last_done, 1 + 96 * 66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
